// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped 16-frame instruction cache, one word per frame
// Optional feature macro: ICACHE_STATS_EN (adds saturating hit_count / miss_count ports)
module icache (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_t;

  state_t      state;

  // Frame storage: valid bit, 26-bit tag and one data word per frame
  logic [15:0] valid;
  logic [25:0] tags [16];
  logic [31:0] data [16];

  // Address of the outstanding miss; the fill always targets this address
  logic [31:0] miss_addr;

  logic [25:0] req_tag;
  logic [3:0]  req_idx;
  logic [25:0] miss_tag;
  logic [3:0]  miss_idx;
  logic        lookup_hit;
  logic        fill_done;

  assign req_tag  = imemaddr[31:6];
  assign req_idx  = imemaddr[5:2];
  assign miss_tag = miss_addr[31:6];
  assign miss_idx = miss_addr[5:2];

  // Lookup is only meaningful in IDLE; FETCH never reports a hit
  assign lookup_hit = (state == IDLE) && imemREN && valid[req_idx] &&
                      (tags[req_idx] == req_tag);

  assign fill_done = (state == FETCH) && !iwait;

  // Zero-latency hit path: data comes straight out of the frame
  always_comb begin
    ihit     = lookup_hit;
    imemload = lookup_hit ? data[req_idx] : 32'h0;
  end

  // Controller FSM, frame fill and registered memory-side request outputs
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      valid     <= '0;
      miss_addr <= '0;
      iREN      <= 1'b0;
      iaddr     <= '0;
      for (int i = 0; i < 16; i++) begin
        tags[i] <= '0;
        data[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (imemREN && !lookup_hit) begin
            state     <= FETCH;
            miss_addr <= imemaddr;
            iREN      <= 1'b1;
            iaddr     <= imemaddr;
          end
        end
        FETCH: begin
          // Datapath inputs are ignored here; the fill completes to miss_addr
          if (!iwait) begin
            valid[miss_idx] <= 1'b1;
            tags[miss_idx]  <= miss_tag;
            data[miss_idx]  <= iload;
            state           <= IDLE;
            iREN            <= 1'b0;
            iaddr           <= '0;
          end
        end
        default: begin
          state <= IDLE;
          iREN  <= 1'b0;
          iaddr <= '0;
        end
      endcase
    end
  end

`ifdef ICACHE_STATS_EN
  logic miss_start;
  assign miss_start = (state == IDLE) && imemREN && !lookup_hit;

  // Saturating hit / miss counters
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (lookup_hit && (hit_count != 32'hFFFF_FFFF))
        hit_count <= hit_count + 32'd1;
      if (miss_start && (miss_count != 32'hFFFF_FFFF))
        miss_count <= miss_count + 32'd1;
    end
  end
`endif

  logic unused_fill;
  assign unused_fill = fill_done;

endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - scoreboard bench for icache against a behavioural cache model
module tb_icache;

  logic        CLK;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  icache dut (
    .CLK(CLK),
    .nRST(nRST),
    .imemREN(imemREN),
    .imemaddr(imemaddr),
    .ihit(ihit),
    .imemload(imemload),
    .iREN(iREN),
    .iaddr(iaddr),
    .iwait(iwait),
    .iload(iload)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count(hit_count),
    .miss_count(miss_count)
`endif
  );

`ifndef ICACHE_STATS_EN
  assign hit_count  = 32'h0;
  assign miss_count = 32'h0;
`endif

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        ihit;
    logic [31:0] load;
    logic        iren;
    logic [31:0] iaddr;
    logic [31:0] hc;
    logic [31:0] mc;
  } exp_t;

  exp_t exp_q[$];

  int n_cmp;
  int n_fail;

  // Reference model: what the cache holds, keyed by frame number
  logic        m_valid [16];
  logic [31:0] m_addr  [16];
  logic [31:0] m_data  [16];
  logic        m_busy;
  logic [31:0] m_faddr;
  logic [31:0] m_hits;
  logic [31:0] m_miss;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h40) return 32'h8C22_0004;
    return a * 32'h9E37_79B1 + 32'h0123_4567;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_addr[i]  = 32'h0;
      m_data[i]  = 32'h0;
    end
    m_busy  = 1'b0;
    m_faddr = 32'h0;
    m_hits  = 32'h0;
    m_miss  = 32'h0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h at %0t", name, act, req, $time);
    end
  endtask

  // One datapath cycle: drive inputs, predict outputs, advance the model
  task automatic step(input logic ren, input logic [31:0] addr, input logic wt, input logic rst);
    exp_t e;
    int   f;
    @(negedge CLK);
    nRST     = !rst;
    imemREN  = ren;
    imemaddr = addr;
    iwait    = wt;
    iload    = (m_busy && !wt && !rst) ? mem_word(m_faddr) : $urandom;
    e.hc = m_hits;
    e.mc = m_miss;
    if (rst) begin
      e.ihit = 0; e.load = 0; e.iren = 0; e.iaddr = 0; e.hc = 0; e.mc = 0;
      model_reset();
    end else if (!m_busy) begin
      f = int'(addr[5:2]);
      e.ihit  = ren && m_valid[f] && (m_addr[f][31:6] == addr[31:6]);
      e.load  = e.ihit ? m_data[f] : 32'h0;
      e.iren  = 0;
      e.iaddr = 0;
      if (e.ihit) begin
        if (m_hits != 32'hFFFF_FFFF) m_hits++;
      end else if (ren) begin
        m_busy  = 1'b1;
        m_faddr = addr;
        if (m_miss != 32'hFFFF_FFFF) m_miss++;
      end
    end else begin
      e.ihit  = 0;
      e.load  = 0;
      e.iren  = 1;
      e.iaddr = m_faddr;
      if (!wt) begin
        f = int'(m_faddr[5:2]);
        m_valid[f] = 1'b1;
        m_addr[f]  = m_faddr;
        m_data[f]  = mem_word(m_faddr);
        m_busy     = 1'b0;
      end
    end
    exp_q.push_back(e);
  endtask

  // Monitor: compare DUT outputs with the oldest prediction each cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("ihit", {31'h0, ihit}, {31'h0, e.ihit});
        chk("imemload", imemload, e.load);
        chk("iREN", {31'h0, iREN}, {31'h0, e.iren});
        chk("iaddr", iaddr, e.iaddr);
`ifdef ICACHE_STATS_EN
        chk("hit_count", hit_count, e.hc);
        chk("miss_count", miss_count, e.mc);
`endif
      end
    end
  end

  initial begin
    logic [31:0] a;
    n_cmp    = 0;
    n_fail   = 0;
    nRST     = 1'b0;
    imemREN  = 1'b0;
    imemaddr = 32'h0;
    iwait    = 1'b1;
    iload    = 32'h0;
    model_reset();

    repeat (3) step(1'b0, 32'h0, 1'b1, 1'b1);

    // Cold miss on 0x40 with three wait cycles, then refetch hits
    step(1'b1, 32'h40, 1'b1, 1'b0);
    repeat (3) step(1'b1, 32'h40, 1'b1, 1'b0);
    step(1'b1, 32'h40, 1'b0, 1'b0);
    step(1'b1, 32'h40, 1'b1, 1'b0);
    step(1'b1, 32'h40, 1'b1, 1'b0);

    // Conflict on frame 0: 0x80 evicts 0x40
    step(1'b1, 32'h80, 1'b1, 1'b0);
    step(1'b1, 32'h80, 1'b0, 1'b0);
    step(1'b1, 32'h80, 1'b1, 1'b0);
    step(1'b1, 32'h40, 1'b0, 1'b0);
    step(1'b1, 32'h40, 1'b0, 1'b0);
    step(1'b1, 32'h40, 1'b1, 1'b0);

    // Address change and request drop during fill of 0x44
    step(1'b1, 32'h44, 1'b1, 1'b0);
    step(1'b1, 32'h48, 1'b1, 1'b0);
    step(1'b0, 32'h48, 1'b1, 1'b0);
    step(1'b1, 32'h48, 1'b0, 1'b0);
    step(1'b1, 32'h48, 1'b0, 1'b0);
    step(1'b1, 32'h48, 1'b0, 1'b0);
    step(1'b1, 32'h44, 1'b1, 1'b0);
    step(1'b1, 32'h48, 1'b1, 1'b0);

    // Idle for ten cycles: nothing moves
    repeat (10) step(1'b0, $urandom, $urandom_range(0, 1) == 1, 1'b0);

    // Reset during a fill of 0x40, then 0x40 misses again
    step(1'b1, 32'h40, 1'b1, 1'b1);
    step(1'b1, 32'h40, 1'b1, 1'b0);
    step(1'b1, 32'hC0, 1'b1, 1'b0);
    step(1'b1, 32'hC0, 1'b1, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b1, 32'h40, 1'b1, 1'b0);
    step(1'b1, 32'h40, 1'b0, 1'b0);
    step(1'b1, 32'h40, 1'b1, 1'b0);

    // Random traffic over a small address space to mix hits and conflicts
    for (int i = 0; i < 3000; i++) begin
      a = {24'h0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'b00};
      if ($urandom_range(0, 7) == 0) a[31:28] = 4'($urandom);
      step($urandom_range(0, 4) != 0, a, $urandom_range(0, 2) == 0,
           $urandom_range(0, 499) == 0);
    end

    step(1'b0, 32'h0, 1'b1, 1'b0);
    @(negedge CLK);
    #4;
    chk("queue_drained", exp_q.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
